// File: rtl/bsg_arb_pkg.sv
// Shared types and constants for the 3-way packet-locking round-robin arbiter.
// The last-grant pointer is one-hot; idx_of() converts it to a requester index.
package bsg_arb_pkg;

    typedef enum logic { e_idle = 1'b0, e_locked = 1'b1 } arb_state_e;

    localparam int els_lp = 3;
    localparam logic [2:0] ptr_reset_lp = 3'b100;

    function automatic logic [1:0] idx_of(input logic [2:0] oh);
        logic [1:0] idx;
        idx = 2'd2;
        case (oh)
            3'b001:  idx = 2'd0;
            3'b010:  idx = 2'd1;
            default: idx = 2'd2;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/bsg_arb_rr_pick_3.sv
// Combinational round-robin pick: first asserted v scanning upward, with wrap,
// from the index just after the one-hot last-grant pointer.
module bsg_arb_rr_pick_3
    import bsg_arb_pkg::*;
(
    input  logic [2:0] v,
    input  logic [2:0] ptr,
    output logic [2:0] grant,
    output logic [1:0] tag,
    output logic       any_v
);

    logic [1:0] pidx;
    assign pidx = idx_of(ptr);

    always_comb begin
        int idx;
        idx   = 0;
        grant = '0;
        tag   = '0;
        any_v = 1'b0;
        for (int k = 1; k <= els_lp; k++) begin
            idx = (int'(pidx) + k) % els_lp;
            if (!any_v && v[idx]) begin
                any_v      = 1'b1;
                grant[idx] = 1'b1;
                tag        = 2'(idx);
            end
        end
    end

endmodule

// File: rtl/bsg_dff_reset_en.sv
// Library flop with synchronous active-high reset and a load enable.
// Tie en_i high to get a plain reset flop.
module bsg_dff_reset_en #(
    parameter int width_p = 3,
    parameter logic [width_p-1:0] reset_val_p = '0
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               en_i,
    input  logic [width_p-1:0] data_i,
    output logic [width_p-1:0] data_o
);

    always_ff @(posedge clk_i) begin
        if (reset_i)
            data_o <= reset_val_p;
        else if (en_i)
            data_o <= data_i;
    end

endmodule

// File: rtl/bsg_rr_arb_lock_3.sv
// Three-requester round-robin arbiter/mux with packet-level lock: once a first
// beat is accepted the grant stays with that requester until its last beat.
module bsg_rr_arb_lock_3
    import bsg_arb_pkg::*;
#(
    parameter int width_p = 32
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic [2:0]             v_i,
    input  logic [3*width_p-1:0]   data_i,
    input  logic [2:0]             last_i,
    output logic [2:0]             yumi_o,
    output logic                   v_o,
    output logic [width_p-1:0]     data_o,
    output logic                   last_o,
    output logic [1:0]             tag_o,
    input  logic                   ready_i,
    output logic                   locked_o
);

    arb_state_e state_r, state_n;
    logic [1:0] lk_r, lk_n;
    logic [2:0] ptr_r;
    logic [2:0] st_q;
    logic       ptr_en;

    logic [2:0] pick_grant;
    logic [1:0] pick_tag;
    logic       pick_any;
    logic [1:0] g;
    logic       locked;
    logic       acc;

    // State and locked index share one width-3 flop; pointer has its own with enable.
    bsg_dff_reset_en #(.width_p(3), .reset_val_p(3'b000)) st_reg (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .en_i   (1'b1),
        .data_i ({state_n, lk_n}),
        .data_o (st_q)
    );

    bsg_dff_reset_en #(.width_p(3), .reset_val_p(ptr_reset_lp)) ptr_reg (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .en_i   (ptr_en),
        .data_i (yumi_o),
        .data_o (ptr_r)
    );

    assign state_r = arb_state_e'(st_q[2]);
    assign lk_r    = st_q[1:0];
    assign locked  = (state_r == e_locked);

    bsg_arb_rr_pick_3 pick (
        .v    (v_i),
        .ptr  (ptr_r),
        .grant(pick_grant),
        .tag  (pick_tag),
        .any_v(pick_any)
    );

    assign g      = locked ? lk_r : pick_tag;
    assign tag_o  = g;
    assign v_o    = v_i[g];
    // Idle with nobody requesting drives a quiet bus rather than slice 0.
    assign data_o = (locked || pick_any) ? data_i[g*width_p +: width_p] : '0;
    assign last_o = (locked || pick_any) ? last_i[g] : 1'b0;
    assign acc    = v_o & ready_i;
    assign yumi_o = acc ? (locked ? (3'b001 << lk_r) : pick_grant) : 3'b000;

    // Pointer only moves when a packet completes; yumi_o is onehot(g) then.
    assign ptr_en   = acc & last_o;
    assign locked_o = locked;

    always_comb begin
        state_n = state_r;
        lk_n    = lk_r;
        if (acc) begin
            case (state_r)
                e_idle: begin
                    if (!last_o) begin
                        state_n = e_locked;
                        lk_n    = g;
                    end
                end
                e_locked: begin
                    if (last_o)
                        state_n = e_idle;
                end
                default: state_n = e_idle;
            endcase
        end
    end

endmodule
